// File: rtl/pipe_id_idex_pkg.sv
// Shared decode constants for the ID stage: opcodes, funct, PCSrc encodings
// and bit positions inside the ID/EX control byte.
package pipe_id_idex_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [2:0] {
    PCSRC_SEQ = 3'd0,
    PCSRC_J   = 3'd2,
    PCSRC_JR  = 3'd3
  } pcsrc_e;

  // idex_ctrl = {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Link, ImmZero}
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_LINK     = 1;
  localparam int CTRL_IMMZERO  = 0;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/pipe_id_idex_if.sv
// Bundle between IF, WB and EX around the ID stage. master = surrounding
// pipeline, slave = the ID stage itself.
interface pipe_id_idex_if;
  logic [63:0] IFID;
  logic        Flush;
  logic        WB_RegWrite;
  logic [4:0]  WB_Rd;
  logic [31:0] WB_Data;

  logic        PCWrite;
  logic        IFIDWrite;
  logic        Stall;
  logic [2:0]  PCSrc;
  logic [25:0] JT;
  logic [31:0] ConBA;
  logic [31:0] DatabusA;
  logic        IFFlush;

  logic [31:0] idex_pc4;
  logic [31:0] idex_a;
  logic [31:0] idex_b;
  logic [31:0] idex_imm;
  logic [4:0]  idex_rs;
  logic [4:0]  idex_rt;
  logic [4:0]  idex_rd;
  logic [7:0]  idex_ctrl;

  modport master (
    output IFID, Flush, WB_RegWrite, WB_Rd, WB_Data,
    input  PCWrite, IFIDWrite, Stall, PCSrc, JT, ConBA, DatabusA, IFFlush,
    input  idex_pc4, idex_a, idex_b, idex_imm, idex_rs, idex_rt, idex_rd, idex_ctrl
  );

  modport slave (
    input  IFID, Flush, WB_RegWrite, WB_Rd, WB_Data,
    output PCWrite, IFIDWrite, Stall, PCSrc, JT, ConBA, DatabusA, IFFlush,
    output idex_pc4, idex_a, idex_b, idex_imm, idex_rs, idex_rt, idex_rd, idex_ctrl
  );
endinterface

// File: rtl/pipe_id_idex_regfile.sv
// 32x32 register file, async read, sync write, $0 hardwired to zero.
// REGFILE_BYPASS_EN adds write-through from the WB port to both read ports.
module pipe_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_ra_a,
  input  logic [4:0]  i_ra_b,
  output logic [31:0] o_rd_a,
  output logic [31:0] o_rd_b
);

  logic [31:0] r_mem [0:31];
  logic        w_wr_en;
  logic [31:0] w_stored_a;
  logic [31:0] w_stored_b;

  assign w_wr_en = i_we && (i_wa != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign w_stored_a = (i_ra_a == 5'd0) ? 32'd0 : r_mem[i_ra_a];
  assign w_stored_b = (i_ra_b == 5'd0) ? 32'd0 : r_mem[i_ra_b];

`ifdef REGFILE_BYPASS_EN
  assign o_rd_a = (w_wr_en && (i_wa == i_ra_a)) ? i_wd : w_stored_a;
  assign o_rd_b = (w_wr_en && (i_wa == i_ra_b)) ? i_wd : w_stored_b;
`else
  assign o_rd_a = w_stored_a;
  assign o_rd_b = w_stored_b;
`endif

endmodule

// File: rtl/pipe_id_idex.sv
// MIPS ID stage + ID/EX register: decode, jump resolve, load-use/jr hazards.
// Optional REGFILE_BYPASS_EN enables WB write-through in pipe_regfile.
module pipe_id_idex
  import pipe_id_idex_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  pipe_id_idex_if.slave bus
);

  logic [31:0] w_pc4, w_instr;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm16;
  logic [31:0] w_rd_a, w_rd_b, w_imm_ext;

  logic [7:0]  w_ctrl;
  logic [4:0]  w_dest;
  logic        w_is_j, w_is_jr;
  logic        w_load_use, w_jr_haz, w_stall, w_bubble;
  pcsrc_e      w_pcsrc;

  logic [31:0] r_pc4, r_a, r_b, r_imm;
  logic [4:0]  r_rs, r_rt, r_rd;
  logic [7:0]  r_ctrl;
  logic [4:0]  r_ld_rd;

  assign w_pc4   = bus.IFID[63:32];
  assign w_instr = bus.IFID[31:0];
  assign w_op    = w_instr[31:26];
  assign w_rs    = w_instr[25:21];
  assign w_rt    = w_instr[20:16];
  assign w_rd    = w_instr[15:11];
  assign w_funct = w_instr[5:0];
  assign w_imm16 = w_instr[15:0];

  pipe_regfile u_regfile (
    .clk    (clk),
    .rst_n  (reset),
    .i_we   (bus.WB_RegWrite),
    .i_wa   (bus.WB_Rd),
    .i_wd   (bus.WB_Data),
    .i_ra_a (w_rs),
    .i_ra_b (w_rt),
    .o_rd_a (w_rd_a),
    .o_rd_b (w_rd_b)
  );

  always_comb begin
    w_ctrl  = '0;
    w_dest  = w_rt;
    w_is_j  = 1'b0;
    w_is_jr = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_dest = w_rd;
        if (w_funct == FN_JR) w_is_jr = 1'b1;
        else                  w_ctrl[CTRL_REGWRITE] = 1'b1;
      end
      OP_LW: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_MEMREAD]  = 1'b1;
        w_ctrl[CTRL_MEMTOREG] = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
      end
      OP_SW: begin
        w_ctrl[CTRL_MEMWRITE] = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
      end
      OP_BEQ:  w_ctrl[CTRL_BRANCH] = 1'b1;
      OP_ADDI: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
      end
      OP_ANDI: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_ctrl[CTRL_IMMZERO]  = 1'b1;
      end
      OP_J:    w_is_j = 1'b1;
      OP_JAL: begin
        w_is_j                = 1'b1;
        w_dest                = 5'd31;
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_LINK]     = 1'b1;
      end
      default: ;
    endcase
    if (w_dest == 5'd0) w_ctrl[CTRL_REGWRITE] = 1'b0;
  end

  assign w_imm_ext = w_ctrl[CTRL_IMMZERO] ? {16'd0, w_imm16} : sext16(w_imm16);

  // r_ld_rd remembers a load that just left EX, so a jr behind it waits a
  // second cycle until the loaded value reaches write-back.
  assign w_load_use = r_ctrl[CTRL_MEMREAD] && (r_rt != 5'd0) &&
                      ((r_rt == w_rs) || (r_rt == w_rt));
  assign w_jr_haz   = w_is_jr &&
                      ((r_ctrl[CTRL_REGWRITE] && (r_rd == w_rs)) ||
                       ((r_ld_rd != 5'd0) && (r_ld_rd == w_rs)));
  assign w_stall    = reset && !bus.Flush && (w_load_use || w_jr_haz);
  assign w_bubble   = bus.Flush || w_stall;

  always_comb begin
    w_pcsrc = PCSRC_SEQ;
    if (reset && !w_bubble) begin
      if (w_is_j)       w_pcsrc = PCSRC_J;
      else if (w_is_jr) w_pcsrc = PCSRC_JR;
    end
  end

  assign bus.PCWrite   = !w_stall;
  assign bus.IFIDWrite = !w_stall;
  assign bus.Stall     = w_stall;
  assign bus.PCSrc     = w_pcsrc;
  assign bus.JT        = w_instr[25:0];
  assign bus.ConBA     = w_pc4 + (sext16(w_imm16) << 2);
  assign bus.DatabusA  = w_rd_a;
  assign bus.IFFlush   = reset && !w_bubble && (w_is_j || w_is_jr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc4   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_ctrl  <= '0;
      r_ld_rd <= '0;
    end else begin
      r_ld_rd <= (r_ctrl[CTRL_MEMREAD] && r_ctrl[CTRL_REGWRITE]) ? r_rd : 5'd0;
      if (w_bubble) begin
        r_pc4  <= '0;
        r_a    <= '0;
        r_b    <= '0;
        r_imm  <= '0;
        r_rs   <= '0;
        r_rt   <= '0;
        r_rd   <= '0;
        r_ctrl <= '0;
      end else begin
        r_pc4  <= w_pc4;
        r_a    <= w_rd_a;
        r_b    <= w_rd_b;
        r_imm  <= w_imm_ext;
        r_rs   <= w_rs;
        r_rt   <= w_rt;
        r_rd   <= w_dest;
        r_ctrl <= w_ctrl;
      end
    end
  end

  assign bus.idex_pc4  = r_pc4;
  assign bus.idex_a    = r_a;
  assign bus.idex_b    = r_b;
  assign bus.idex_imm  = r_imm;
  assign bus.idex_rs   = r_rs;
  assign bus.idex_rt   = r_rt;
  assign bus.idex_rd   = r_rd;
  assign bus.idex_ctrl = r_ctrl;

endmodule
